nn_weight_loader: RTL

- Write-side sequencer for the MLP inference top.
- Accepts a flat valid/ready stream of 16-bit words and translates it into the load interface consumed by the network's storage:
  - layer-1 and layer-2 weight RAM enables `en[1:0]`
  - one-hot per-RAM write strobes `we`
  - `addr` / `wdata`
  - activation-table strobe `active_we`
- Sits between the host/DMA word source and the network top; the network loads only through this block.

---
 rtl/nn_weight_loader_if.sv | 21 ++
 rtl/nn_weight_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/nn_weight_loader_if.sv
// Word stream into the weight loader: valid/ready plus one data word.
// The source drives valid/data; the loader answers with ready.
interface nn_weight_loader_if #(
  parameter int DATA_W = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/nn_weight_loader.sv
// Write-side sequencer: turns a flat word stream into activation-table,
// layer-1 and layer-2 RAM write strobes in RAM-major order.
module nn_weight_loader #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 18,
  parameter int N_L1      = 784,
  parameter int N_L2      = 10,
  parameter int DEPTH_L1  = 16,
  parameter int DEPTH_L2  = 16,
  parameter int ACT_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  nn_weight_loader_if.slave    s,
  output logic [1:0]           en,
  output logic [N_L1+N_L2-1:0] we,
  output logic                 active_we,
  output logic [ADDR_W-1:0]    addr,
  output logic [DATA_W-1:0]    wdata,
  output logic                 busy,
  output logic                 done
);

  localparam int WE_W = N_L1 + N_L2;
  localparam int MD1  = (DEPTH_L1 > DEPTH_L2) ? DEPTH_L1 : DEPTH_L2;
  localparam int MAXD = (ACT_DEPTH > MD1) ? ACT_DEPTH : MD1;
  localparam int MAXN = (N_L1 > N_L2) ? N_L1 : N_L2;
  localparam int WC_W = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam int RC_W = (MAXN > 1) ? $clog2(MAXN) : 1;

  localparam logic [WE_W-1:0] WE_ONE   = WE_W'(1);
  localparam logic [WC_W-1:0] ACT_LAST = WC_W'(ACT_DEPTH - 1);
  localparam logic [WC_W-1:0] L1_LAST  = WC_W'(DEPTH_L1 - 1);
  localparam logic [WC_W-1:0] L2_LAST  = WC_W'(DEPTH_L2 - 1);
  localparam logic [RC_W-1:0] R1_LAST  = RC_W'(N_L1 - 1);
  localparam logic [RC_W-1:0] R2_LAST  = RC_W'(N_L2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_ACT,
    LOAD_L1,
    LOAD_L2,
    FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   word_q, word_d;
  logic [RC_W-1:0]   ram_q, ram_d;
  logic [1:0]        en_q, en_d;
  logic [WE_W-1:0]   we_q, we_d;
  logic              act_q, act_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              acc;

  assign s.s_ready = (state_q == LOAD_ACT) ||
                     (state_q == LOAD_L1) ||
                     (state_q == LOAD_L2);
  assign acc = s.s_valid && s.s_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    ram_d   = ram_q;
    en_d    = 2'b00;
    we_d    = '0;
    act_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (acc) begin
      addr_d  = ADDR_W'(word_q);
      wdata_d = s.s_data;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_ACT;
          word_d  = '0;
          ram_d   = '0;
          busy_d  = 1'b1;
        end
      end
      LOAD_ACT: begin
        if (acc) begin
          act_d = 1'b1;
          if (word_q == ACT_LAST) begin
            word_d  = '0;
            state_d = LOAD_L1;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      LOAD_L1: begin
        if (acc) begin
          en_d = 2'b01;
          we_d = WE_ONE << ram_q;
          if (word_q == L1_LAST) begin
            word_d = '0;
            if (ram_q == R1_LAST) begin
              ram_d   = '0;
              state_d = LOAD_L2;
            end else begin
              ram_d = ram_q + 1'b1;
            end
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      LOAD_L2: begin
        if (acc) begin
          en_d = 2'b10;
          we_d = WE_ONE << (N_L1 + int'(ram_q));
          if (word_q == L2_LAST) begin
            word_d = '0;
            if (ram_q == R2_LAST) begin
              ram_d   = '0;
              state_d = FINISH;
              done_d  = 1'b1;
            end else begin
              ram_d = ram_q + 1'b1;
            end
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      FINISH: begin
        // done cycle: a start here chains straight into the next load
        if (start) begin
          state_d = LOAD_ACT;
          word_d  = '0;
          ram_d   = '0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      ram_q   <= '0;
      en_q    <= '0;
      we_q    <= '0;
      act_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      ram_q   <= ram_d;
      en_q    <= en_d;
      we_q    <= we_d;
      act_q   <= act_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign en        = en_q;
  assign we        = we_q;
  assign active_we = act_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
